// File: rtl/axi4_slave_mem.sv
// axi4_slave_mem
//   AXI4 slave carrying a word RAM. Independent write (AW/W/B) and read (AR/R)
//   FSMs, one outstanding transaction per direction, FIXED/INCR/WRAP bursts.
//
// Ports
//   clk, rst           : single clock, synchronous active-high reset
//   S_AXI_AW*          : write address channel (ADDR/LEN/SIZE/BURST/VALID/READY)
//   S_AXI_W*           : write data channel (DATA/STRB/LAST/VALID/READY)
//   S_AXI_B*           : write response channel (RESP/VALID/READY)
//   S_AXI_AR*          : read address channel, same encoding as AW
//   S_AXI_R*           : read data channel (DATA/RESP/LAST/VALID/READY)
//
// Handshake: a transfer happens on every rising clk edge where VALID and
// READY are both high; the sender holds its payload stable until then.
//
// Build option
//   AXI_SLV_DECERR_EN : when defined, beats addressed at or above MEM_DEPTH*4
//                       are not written, read as 0 and answer DECERR. When
//                       undefined, upper address bits are ignored (aliasing).
module axi4_slave_mem #(
    parameter int ADDR_WIDTH = 32,
    parameter int DATA_WIDTH = 32,
    parameter int MEM_DEPTH  = 1024
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic [ADDR_WIDTH-1:0]   S_AXI_AWADDR,
    input  logic [7:0]              S_AXI_AWLEN,
    input  logic [2:0]              S_AXI_AWSIZE,
    input  logic [1:0]              S_AXI_AWBURST,
    input  logic                    S_AXI_AWVALID,
    output logic                    S_AXI_AWREADY,
    input  logic [DATA_WIDTH-1:0]   S_AXI_WDATA,
    input  logic [DATA_WIDTH/8-1:0] S_AXI_WSTRB,
    input  logic                    S_AXI_WLAST,
    input  logic                    S_AXI_WVALID,
    output logic                    S_AXI_WREADY,
    output logic [1:0]              S_AXI_BRESP,
    output logic                    S_AXI_BVALID,
    input  logic                    S_AXI_BREADY,
    input  logic [ADDR_WIDTH-1:0]   S_AXI_ARADDR,
    input  logic [7:0]              S_AXI_ARLEN,
    input  logic [2:0]              S_AXI_ARSIZE,
    input  logic [1:0]              S_AXI_ARBURST,
    input  logic                    S_AXI_ARVALID,
    output logic                    S_AXI_ARREADY,
    output logic [DATA_WIDTH-1:0]   S_AXI_RDATA,
    output logic [1:0]              S_AXI_RRESP,
    output logic                    S_AXI_RLAST,
    output logic                    S_AXI_RVALID,
    input  logic                    S_AXI_RREADY
);
    localparam int IDX_W  = $clog2(MEM_DEPTH);
    localparam int STRB_W = DATA_WIDTH / 8;
`ifdef AXI_SLV_DECERR_EN
    localparam bit DECODE_EN = 1'b1;
`else
    localparam bit DECODE_EN = 1'b0;
`endif
    localparam logic [1:0] RESP_OKAY   = 2'd0;
    localparam logic [1:0] RESP_SLVERR = 2'd2;
    localparam logic [1:0] RESP_DECERR = 2'd3;
    localparam logic [1:0] BURST_FIXED = 2'd0;
    localparam logic [1:0] BURST_WRAP  = 2'd2;

    typedef enum logic [1:0] {W_IDLE, W_DATA, W_RESP} w_state_e;
    typedef enum logic       {R_IDLE, R_DATA}         r_state_e;

    function automatic logic [ADDR_WIDTH-1:0] next_addr(input logic [ADDR_WIDTH-1:0] addr,
                                                        input logic [7:0] len,
                                                        input logic [2:0] size,
                                                        input logic [1:0] burst);
        logic [ADDR_WIDTH-1:0] step;
        logic [ADDR_WIDTH-1:0] mask;
        step = ADDR_WIDTH'(1) << size;
        // mask = total burst bytes - 1; the wrap boundary is addr & ~mask
        mask = ((ADDR_WIDTH'(len) + ADDR_WIDTH'(1)) << size) - ADDR_WIDTH'(1);
        case (burst)
            BURST_FIXED: next_addr = addr;
            BURST_WRAP:  next_addr = (addr & ~mask) | ((addr + step) & mask);
            default:     next_addr = addr + step;
        endcase
    endfunction

    // Reserved burst type 3 is rejected together with bad WRAP lengths and
    // beats wider than the 32-bit bus.
    function automatic logic is_illegal(input logic [7:0] len, input logic [2:0] size,
                                        input logic [1:0] burst);
        logic wrap_len_ok;
        wrap_len_ok = (len == 8'd1) || (len == 8'd3) || (len == 8'd7) || (len == 8'd15);
        is_illegal  = (size > 3'd2) || (burst == 2'd3) || ((burst == BURST_WRAP) && !wrap_len_ok);
    endfunction

    function automatic logic is_decerr(input logic [ADDR_WIDTH-1:0] addr);
        is_decerr = DECODE_EN && (addr[ADDR_WIDTH-1:IDX_W+2] != '0);
    endfunction

    logic [DATA_WIDTH-1:0] mem [MEM_DEPTH];

    // Holds the address-channel READYs low until the first cycle after reset.
    logic ready_en_q;

    w_state_e              w_state_q, w_state_d;
    logic [ADDR_WIDTH-1:0] w_addr_q, w_addr_d;
    logic [7:0]            w_len_q, w_len_d, w_cnt_q, w_cnt_d;
    logic [2:0]            w_size_q, w_size_d;
    logic [1:0]            w_burst_q, w_burst_d;
    logic                  w_ill_q, w_ill_d, w_slverr_q, w_slverr_d, w_decerr_q, w_decerr_d;
    logic                  mem_we;

    r_state_e              r_state_q, r_state_d;
    logic [ADDR_WIDTH-1:0] r_addr_q, r_addr_d, fetch_addr;
    logic [7:0]            r_len_q, r_len_d, r_cnt_q, r_cnt_d;
    logic [2:0]            r_size_q, r_size_d;
    logic [1:0]            r_burst_q, r_burst_d;
    logic                  r_ill_q, r_ill_d, fetch, fetch_ill;
    logic [DATA_WIDTH-1:0] rdata_q, rdata_d;

    // ---------------- write path ----------------
    always_comb begin
        w_state_d  = w_state_q;
        w_addr_d   = w_addr_q;
        w_len_d    = w_len_q;
        w_cnt_d    = w_cnt_q;
        w_size_d   = w_size_q;
        w_burst_d  = w_burst_q;
        w_ill_d    = w_ill_q;
        w_slverr_d = w_slverr_q;
        w_decerr_d = w_decerr_q;
        mem_we     = 1'b0;
        case (w_state_q)
            W_IDLE: begin
                if (S_AXI_AWVALID && S_AXI_AWREADY) begin
                    w_addr_d   = S_AXI_AWADDR;
                    w_len_d    = S_AXI_AWLEN;
                    w_size_d   = S_AXI_AWSIZE;
                    w_burst_d  = S_AXI_AWBURST;
                    w_cnt_d    = 8'd0;
                    w_ill_d    = is_illegal(S_AXI_AWLEN, S_AXI_AWSIZE, S_AXI_AWBURST);
                    w_slverr_d = w_ill_d;
                    w_decerr_d = 1'b0;
                    w_state_d  = W_DATA;
                end
            end
            W_DATA: begin
                if (S_AXI_WVALID) begin
                    // A dropped transaction must not leave a write behind.
                    mem_we = !rst && !w_ill_q && !is_decerr(w_addr_q);
                    if (S_AXI_WLAST != (w_cnt_q == w_len_q)) w_slverr_d = 1'b1;
                    if (is_decerr(w_addr_q)) w_decerr_d = 1'b1;
                    w_addr_d = next_addr(w_addr_q, w_len_q, w_size_q, w_burst_q);
                    w_cnt_d  = w_cnt_q + 8'd1;
                    if (w_cnt_q == w_len_q) w_state_d = W_RESP;
                end
            end
            W_RESP: begin
                if (S_AXI_BREADY) w_state_d = W_IDLE;
            end
            default: w_state_d = W_IDLE;
        endcase
    end

    assign S_AXI_AWREADY = ready_en_q && (w_state_q == W_IDLE);
    assign S_AXI_WREADY  = (w_state_q == W_DATA);
    assign S_AXI_BVALID  = (w_state_q == W_RESP);
    assign S_AXI_BRESP   = !S_AXI_BVALID ? RESP_OKAY :
                           w_decerr_q    ? RESP_DECERR :
                           w_slverr_q    ? RESP_SLVERR : RESP_OKAY;

    always_ff @(posedge clk) begin
        if (mem_we) begin
            for (int b = 0; b < STRB_W; b++) begin
                if (S_AXI_WSTRB[b]) mem[w_addr_q[IDX_W+1:2]][8*b +: 8] <= S_AXI_WDATA[8*b +: 8];
            end
        end
    end

    // ---------------- read path ----------------
    always_comb begin
        r_state_d  = r_state_q;
        r_addr_d   = r_addr_q;
        r_len_d    = r_len_q;
        r_cnt_d    = r_cnt_q;
        r_size_d   = r_size_q;
        r_burst_d  = r_burst_q;
        r_ill_d    = r_ill_q;
        rdata_d    = rdata_q;
        fetch      = 1'b0;
        fetch_addr = r_addr_q;
        fetch_ill  = r_ill_q;
        case (r_state_q)
            R_IDLE: begin
                if (S_AXI_ARVALID && S_AXI_ARREADY) begin
                    r_addr_d   = S_AXI_ARADDR;
                    r_len_d    = S_AXI_ARLEN;
                    r_size_d   = S_AXI_ARSIZE;
                    r_burst_d  = S_AXI_ARBURST;
                    r_cnt_d    = 8'd0;
                    r_ill_d    = is_illegal(S_AXI_ARLEN, S_AXI_ARSIZE, S_AXI_ARBURST);
                    fetch      = 1'b1;
                    fetch_addr = S_AXI_ARADDR;
                    fetch_ill  = r_ill_d;
                    r_state_d  = R_DATA;
                end
            end
            R_DATA: begin
                if (S_AXI_RREADY) begin
                    if (r_cnt_q == r_len_q) begin
                        r_state_d = R_IDLE;
                    end else begin
                        r_addr_d   = next_addr(r_addr_q, r_len_q, r_size_q, r_burst_q);
                        r_cnt_d    = r_cnt_q + 8'd1;
                        fetch      = 1'b1;
                        fetch_addr = r_addr_d;
                    end
                end
            end
            default: r_state_d = R_IDLE;
        endcase
        // The next beat is fetched at the handshake, so RDATA stays put while
        // the master stalls and a same-cycle write to that word is not seen.
        if (fetch) rdata_d = (fetch_ill || is_decerr(fetch_addr)) ? '0 : mem[fetch_addr[IDX_W+1:2]];
    end

    assign S_AXI_ARREADY = ready_en_q && (r_state_q == R_IDLE);
    assign S_AXI_RVALID  = (r_state_q == R_DATA);
    assign S_AXI_RLAST   = S_AXI_RVALID && (r_cnt_q == r_len_q);
    assign S_AXI_RDATA   = rdata_q;
    assign S_AXI_RRESP   = !S_AXI_RVALID       ? RESP_OKAY :
                           is_decerr(r_addr_q) ? RESP_DECERR :
                           r_ill_q             ? RESP_SLVERR : RESP_OKAY;

    // ---------------- state registers ----------------
    always_ff @(posedge clk) begin
        if (rst) begin
            ready_en_q <= 1'b0;
            w_state_q  <= W_IDLE;
            w_addr_q   <= '0;
            w_len_q    <= '0;
            w_cnt_q    <= '0;
            w_size_q   <= '0;
            w_burst_q  <= '0;
            w_ill_q    <= 1'b0;
            w_slverr_q <= 1'b0;
            w_decerr_q <= 1'b0;
            r_state_q  <= R_IDLE;
            r_addr_q   <= '0;
            r_len_q    <= '0;
            r_cnt_q    <= '0;
            r_size_q   <= '0;
            r_burst_q  <= '0;
            r_ill_q    <= 1'b0;
            rdata_q    <= '0;
        end else begin
            ready_en_q <= 1'b1;
            w_state_q  <= w_state_d;
            w_addr_q   <= w_addr_d;
            w_len_q    <= w_len_d;
            w_cnt_q    <= w_cnt_d;
            w_size_q   <= w_size_d;
            w_burst_q  <= w_burst_d;
            w_ill_q    <= w_ill_d;
            w_slverr_q <= w_slverr_d;
            w_decerr_q <= w_decerr_d;
            r_state_q  <= r_state_d;
            r_addr_q   <= r_addr_d;
            r_len_q    <= r_len_d;
            r_cnt_q    <= r_cnt_d;
            r_size_q   <= r_size_d;
            r_burst_q  <= r_burst_d;
            r_ill_q    <= r_ill_d;
            rdata_q    <= rdata_d;
        end
    end
endmodule
